lru_stats_digit_sched: RTL and testbench



---
 rtl/lru_vga_pkg.sv | 25 ++
 rtl/bin2bcd_seq.sv | 81 ++++++++
 rtl/lru_stats_digit_sched.sv | 157 +++++++++++++++
 tb/tb_lru_stats_digit_sched.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/lru_vga_pkg.sv
// -----------------------------------------------------------------------------
// lru_vga_pkg
// Shared definitions for the LRU cache demo VGA stats overlay: the digit
// scheduler state encoding, the blank digit code (the overlay renderer draws
// no glyph for it) and the default statistics geometry.
// -----------------------------------------------------------------------------
package lru_vga_pkg;

    localparam int NUM_STATS_DEF = 8;
    localparam int STAT_W_DEF    = 11;
    localparam int DIGITS_DEF    = 4;

    // Digit code the renderer maps to an empty cell.
    localparam logic [3:0] DIGIT_BLANK = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LATCH,
        ST_LOAD,
        ST_SHIFT,
        ST_WRITE,
        ST_DONE
    } sched_state_t;

endpackage

// File: rtl/bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq
// Sequential double-dabble converter. A start pulse loads the binary operand
// and clears the BCD accumulator; each following cycle performs one
// add-3/shift step, STAT_W steps in total.
//
// Ports:
//   clk      clock
//   rst_n    synchronous active-low reset (control only)
//   start    load bin_in and begin a conversion
//   bin_in   binary operand, sampled on start
//   done     high during the final shift cycle; bcd holds the full result
//            from the next cycle until the next start
//   bcd      BCD accumulator, DIGITS nibbles, most significant nibble on top
//   bcd_nxt  value bcd takes after the current shift step; lets the caller
//            capture the most significant digit in the same cycle the
//            conversion finishes
//
// STAT_W must satisfy 2^STAT_W-1 < 10^DIGITS or the top digit overflows.
// -----------------------------------------------------------------------------
module bin2bcd_seq #(
    parameter int STAT_W = 11,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [STAT_W-1:0]     bin_in,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [4*DIGITS-1:0]   bcd_nxt
);

    localparam int            CW   = $clog2(STAT_W + 1);
    localparam logic [CW-1:0] LAST = CW'(STAT_W - 1);

    logic [STAT_W-1:0]   bin_sr;
    logic [4*DIGITS-1:0] adj;
    logic [CW-1:0]       cnt;
    logic                active;

    // Add 3 to every nibble >= 5 so the following left shift carries
    // correctly into the next decimal digit.
    always_comb begin
        adj = bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[i*4 +: 4] >= 4'd5) begin
                adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
            end
        end
        bcd_nxt = {adj[4*DIGITS-2:0], bin_sr[STAT_W-1]};
    end

    assign done = active && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            active <= 1'b0;
            cnt    <= '0;
        end else if (start) begin
            active <= 1'b1;
            cnt    <= '0;
        end else if (active) begin
            cnt <= cnt + CW'(1);
            if (done) begin
                active <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (start) begin
            bin_sr <= bin_in;
            bcd    <= '0;
        end else if (active) begin
            bin_sr <= {bin_sr[STAT_W-2:0], 1'b0};
            bcd    <= bcd_nxt;
        end
    end

endmodule

// File: rtl/lru_stats_digit_sched.sv
// -----------------------------------------------------------------------------
// lru_stats_digit_sched
// Once per frame, snapshots the LRU cache statistics counters, converts each
// to DIGITS decimal digits and writes the digit codes (MSD first, optional
// leading-zero blanking) into the overlay digit RAM through one write port.
//
// Ports:
//   clk          pixel/system clock
//   rst_n        synchronous active-low reset; aborts a pass immediately
//   en           when low, frame_start is ignored in IDLE
//   frame_start  one-cycle pulse at start of vertical blank
//   stats_flat   counter i at bits [i*STAT_W +: STAT_W]
//   wr_en        digit RAM write strobe
//   wr_addr      {stat_idx, digit_idx}, digit_idx 0 = most significant
//   wr_data      BCD digit 0-9 or DIGIT_BLANK
//   busy         high from LATCH through the final WRITE
//   done         one-cycle pulse after the last write of a pass
//   overrun      one-cycle pulse when frame_start arrives while a pass runs
// All outputs are registered: each is loaded from the value implied by the
// next state, so it lines up with the state it describes.
// -----------------------------------------------------------------------------
module lru_stats_digit_sched
    import lru_vga_pkg::*;
#(
    parameter int NUM_STATS = NUM_STATS_DEF,
    parameter int STAT_W    = STAT_W_DEF,
    parameter int DIGITS    = DIGITS_DEF,
    parameter int BLANK_LZ  = 1
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      en,
    input  logic                                      frame_start,
    input  logic [NUM_STATS*STAT_W-1:0]               stats_flat,
    output logic                                      wr_en,
    output logic [$clog2(NUM_STATS)+$clog2(DIGITS)-1:0] wr_addr,
    output logic [3:0]                                wr_data,
    output logic                                      busy,
    output logic                                      done,
    output logic                                      overrun
);

    localparam int            SW     = $clog2(NUM_STATS);
    localparam int            DW     = $clog2(DIGITS);
    localparam logic [SW-1:0] LAST_S = SW'(NUM_STATS - 1);
    localparam logic [DW-1:0] LAST_D = DW'(DIGITS - 1);

    sched_state_t state, next_state;

    logic [NUM_STATS*STAT_W-1:0] snap;
    logic [SW-1:0]               stat_idx;
    logic [DW-1:0]               digit_idx;
    logic                        lz_flag;

    logic                        conv_start;
    logic                        conv_done;
    logic [4*DIGITS-1:0]         conv_bcd;
    logic [4*DIGITS-1:0]         conv_bcd_nxt;
    logic [STAT_W-1:0]           conv_bin;

    logic [4*DIGITS-1:0]         sel_bcd;
    logic [DW-1:0]               nxt_didx;
    logic [3:0]                  nxt_digit;
    logic                        lz_in;
    logic                        blank;
    logic [3:0]                  nxt_wr_data;

    assign conv_start = (state == ST_LOAD);
    assign conv_bin   = snap[int'(stat_idx)*STAT_W +: STAT_W];

    bin2bcd_seq #(
        .STAT_W (STAT_W),
        .DIGITS (DIGITS)
    ) u_bin2bcd (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (conv_start),
        .bin_in  (conv_bin),
        .done    (conv_done),
        .bcd     (conv_bcd),
        .bcd_nxt (conv_bcd_nxt)
    );

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (frame_start && en) next_state = ST_LATCH;
            ST_LATCH: next_state = ST_LOAD;
            ST_LOAD:  next_state = ST_SHIFT;
            ST_SHIFT: if (conv_done) next_state = ST_WRITE;
            ST_WRITE: begin
                if (digit_idx == LAST_D) begin
                    next_state = (stat_idx == LAST_S) ? ST_DONE : ST_LOAD;
                end
            end
            ST_DONE:  next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    // Digit for the write that the next cycle presents. Entering WRITE from
    // SHIFT the converter is still taking its last step, so the MSD comes
    // from its look-ahead value; later digits come from the settled result.
    always_comb begin
        sel_bcd     = (state == ST_SHIFT) ? conv_bcd_nxt : conv_bcd;
        nxt_didx    = (state == ST_WRITE) ? digit_idx + DW'(1) : '0;
        nxt_digit   = sel_bcd[(DIGITS - 1 - int'(nxt_didx))*4 +: 4];
        lz_in       = (state == ST_WRITE) ? lz_flag : 1'b1;
        blank       = (BLANK_LZ != 0) && lz_in && (nxt_digit == 4'd0) &&
                      (nxt_didx != LAST_D);
        nxt_wr_data = blank ? DIGIT_BLANK : nxt_digit;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            stat_idx  <= '0;
            digit_idx <= '0;
            lz_flag   <= 1'b0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state   <= next_state;
            wr_en   <= (next_state == ST_WRITE);
            busy    <= (next_state == ST_LATCH) || (next_state == ST_LOAD) ||
                       (next_state == ST_SHIFT) || (next_state == ST_WRITE);
            done    <= (next_state == ST_DONE);
            overrun <= frame_start && (state != ST_IDLE);

            if (state == ST_LATCH) begin
                stat_idx <= '0;
            end else if (state == ST_WRITE && digit_idx == LAST_D &&
                         stat_idx != LAST_S) begin
                stat_idx <= stat_idx + SW'(1);
            end

            if (next_state == ST_WRITE) begin
                digit_idx <= nxt_didx;
                lz_flag   <= blank;
                wr_addr   <= {stat_idx, nxt_didx};
                wr_data   <= nxt_wr_data;
            end
        end
    end

    // Snapshot is pure data: only taken in LATCH, so no reset needed.
    always_ff @(posedge clk) begin
        if (state == ST_LATCH) begin
            snap <= stats_flat;
        end
    end

endmodule

// File: tb/tb_lru_stats_digit_sched.sv
// -----------------------------------------------------------------------------
// tb_lru_stats_digit_sched
// Directed bench for lru_stats_digit_sched. Two instances share inputs: one
// with leading-zero blanking, one without. Cycle numbering follows the
// frame_start convention: the cycle frame_start is driven is cycle 0, so the
// first observation after the sampling edge is cycle 1 (LATCH).
// -----------------------------------------------------------------------------
module tb_lru_stats_digit_sched;

    localparam int NS = 8;
    localparam int SW = 11;
    localparam int AW = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_n;
    logic               en;
    logic               frame_start;
    logic [NS*SW-1:0]   stats_flat;

    logic               wr_en_a,  wr_en_b;
    logic [AW-1:0]      wr_addr_a, wr_addr_b;
    logic [3:0]         wr_data_a, wr_data_b;
    logic               busy_a,   busy_b;
    logic               done_a,   done_b;
    logic               overrun_a, overrun_b;

    lru_stats_digit_sched #(.NUM_STATS(NS), .STAT_W(SW), .DIGITS(4), .BLANK_LZ(1)) u_dut_lz (
        .clk(clk), .rst_n(rst_n), .en(en), .frame_start(frame_start),
        .stats_flat(stats_flat), .wr_en(wr_en_a), .wr_addr(wr_addr_a),
        .wr_data(wr_data_a), .busy(busy_a), .done(done_a), .overrun(overrun_a)
    );

    lru_stats_digit_sched #(.NUM_STATS(NS), .STAT_W(SW), .DIGITS(4), .BLANK_LZ(0)) u_dut_nolz (
        .clk(clk), .rst_n(rst_n), .en(en), .frame_start(frame_start),
        .stats_flat(stats_flat), .wr_en(wr_en_b), .wr_addr(wr_addr_b),
        .wr_data(wr_data_b), .busy(busy_b), .done(done_b), .overrun(overrun_b)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [3:0]  ram_a [32];
    logic [3:0]  ram_b [32];
    int          nwr_a, nwr_b, order_err, first_wr, last_wr;
    int          done_cyc, ndone, ov_cyc, nov, nwr_post;
    logic        bz [0:255];
    logic [31:0] post_rst_outs;
    logic [NS*SW-1:0] vec;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NS*SW-1:0] mk(input int a0, a1, a2, a3, a4, a5, a6, a7);
        return {SW'(a7), SW'(a6), SW'(a5), SW'(a4), SW'(a3), SW'(a2), SW'(a1), SW'(a0)};
    endfunction

    function automatic logic [15:0] wa(input int s);
        return {ram_a[4*s], ram_a[4*s+1], ram_a[4*s+2], ram_a[4*s+3]};
    endfunction

    function automatic logic [15:0] wb(input int s);
        return {ram_b[4*s], ram_b[4*s+1], ram_b[4*s+2], ram_b[4*s+3]};
    endfunction

    // Pulse frame_start (with en_v), then run ncyc cycles recording writes.
    // fs_a/fs_b: extra frame_start cycles; rst_at: cycle reset is driven.
    task automatic run_pass(input logic [NS*SW-1:0] stats, input bit en_v,
                            input int fs_a, input int fs_b, input int rst_at,
                            input bit scram, input int ncyc);
        int exp_addr;
        logic [95:0] rnd;
        exp_addr = 0;
        for (int i = 0; i < 32; i++) begin
            ram_a[i] = 4'hE;
            ram_b[i] = 4'hE;
        end
        for (int i = 0; i < 256; i++) bz[i] = 1'b0;
        nwr_a = 0; nwr_b = 0; order_err = 0; first_wr = -1; last_wr = -1;
        done_cyc = -1; ndone = 0; ov_cyc = -1; nov = 0; nwr_post = 0;
        post_rst_outs = '1;
        rst_n = 1'b1;
        stats_flat = stats;
        en = en_v;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        for (int cyc = 1; cyc <= ncyc; cyc++) begin
            bz[cyc] = busy_a;
            if (wr_en_a) begin
                ram_a[wr_addr_a] = wr_data_a;
                if (int'(wr_addr_a) != exp_addr) order_err++;
                exp_addr++;
                nwr_a++;
                if (first_wr < 0) first_wr = cyc;
                last_wr = cyc;
                if (rst_at > 0 && cyc > rst_at) nwr_post++;
            end
            if (wr_en_b) begin
                ram_b[wr_addr_b] = wr_data_b;
                nwr_b++;
            end
            if (done_a) begin
                ndone++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (overrun_a) begin
                nov++;
                if (ov_cyc < 0) ov_cyc = cyc;
            end
            if (cyc == rst_at + 1)
                post_rst_outs = {17'd0, wr_en_a, wr_addr_a, wr_data_a, busy_a,
                                 done_a, overrun_a, wr_en_b, busy_b};
            frame_start = (cyc == fs_a) || (cyc == fs_b);
            rst_n = (cyc != rst_at);
            if (scram && cyc >= 2) begin
                rnd = {$urandom(), $urandom(), $urandom()};
                stats_flat = rnd[NS*SW-1:0];
            end
            step();
        end
        frame_start = 1'b0;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        en = 1'b0;
        frame_start = 1'b0;
        stats_flat = '0;
        vec = '0;
        repeat (3) step();
        chk("rst_wr_en",   32'(wr_en_a),   32'd0);
        chk("rst_wr_addr", 32'(wr_addr_a), 32'd0);
        chk("rst_wr_data", 32'(wr_data_a), 32'd0);
        chk("rst_busy",    32'(busy_a),    32'd0);
        chk("rst_done",    32'(done_a),    32'd0);
        chk("rst_overrun", 32'(overrun_a), 32'd0);
        rst_n = 1'b1;
        step();

        // All zero stats; frame_start during DONE only raises overrun.
        run_pass('0, 1'b1, 130, -1, -1, 1'b0, 135);
        chk("z_nwr",      32'(nwr_a),     32'd32);
        chk("z_order",    32'(order_err), 32'd0);
        chk("z_first_wr", 32'(first_wr),  32'd14);
        chk("z_last_wr",  32'(last_wr),   32'd129);
        chk("z_done_cyc", 32'(done_cyc),  32'd130);
        chk("z_ndone",    32'(ndone),     32'd1);
        chk("z_busy1",    32'(bz[1]),     32'd1);
        chk("z_busy129",  32'(bz[129]),   32'd1);
        chk("z_busy130",  32'(bz[130]),   32'd0);
        chk("z_ov_cyc",   32'(ov_cyc),    32'd131);
        chk("z_nov",      32'(nov),       32'd1);
        chk("z_busy132",  32'(bz[132]),   32'd0);
        for (int s = 0; s < NS; s++) begin
            chk($sformatf("z_lz_s%0d", s),   32'(wa(s)), 32'hFFF0);
            chk($sformatf("z_nolz_s%0d", s), 32'(wb(s)), 32'h0000);
        end
        chk("z_nwr_b", 32'(nwr_b), 32'd32);

        // Mixed values, both blanking modes.
        vec = mk(2047, 1000, 5, 42, 0, 0, 0, 999);
        run_pass(vec, 1'b1, -1, -1, -1, 1'b0, 135);
        chk("v_nwr",     32'(nwr_a),    32'd32);
        chk("v_done",    32'(done_cyc), 32'd130);
        chk("v_s0",      32'(wa(0)),    32'h2047);
        chk("v_s1",      32'(wa(1)),    32'h1000);
        chk("v_s2",      32'(wa(2)),    32'hFFF5);
        chk("v_s3",      32'(wa(3)),    32'hFF42);
        chk("v_s4",      32'(wa(4)),    32'hFFF0);
        chk("v_s7",      32'(wa(7)),    32'hF999);
        chk("v_nolz_s2", 32'(wb(2)),    32'h0005);
        chk("v_nolz_s3", 32'(wb(3)),    32'h0042);
        chk("v_nolz_s7", 32'(wb(7)),    32'h0999);

        // Inputs scrambled from cycle 2; overrun at 50; restart accepted at 131.
        vec = mk(123, 10, 2000, 42, 7, 100, 1999, 2047);
        run_pass(vec, 1'b1, 50, 131, -1, 1'b1, 135);
        chk("s_nwr",     32'(nwr_a),     32'd32);
        chk("s_order",   32'(order_err), 32'd0);
        chk("s_done",    32'(done_cyc),  32'd130);
        chk("s_ov_cyc",  32'(ov_cyc),    32'd51);
        chk("s_nov",     32'(nov),       32'd1);
        chk("s_busy132", 32'(bz[132]),   32'd1);
        chk("s_s0", 32'(wa(0)), 32'hF123);
        chk("s_s1", 32'(wa(1)), 32'hFF10);
        chk("s_s2", 32'(wa(2)), 32'h2000);
        chk("s_s3", 32'(wa(3)), 32'hFF42);
        chk("s_s4", 32'(wa(4)), 32'hFFF7);
        chk("s_s5", 32'(wa(5)), 32'hF100);
        chk("s_s6", 32'(wa(6)), 32'h1999);
        chk("s_s7", 32'(wa(7)), 32'h2047);
        repeat (140) step();

        // en low: frame_start ignored entirely.
        run_pass(vec, 1'b0, -1, -1, -1, 1'b0, 20);
        chk("en0_nwr",   32'(nwr_a), 32'd0);
        chk("en0_busy1", 32'(bz[1]), 32'd0);
        chk("en0_nov",   32'(nov),   32'd0);
        chk("en0_ndone", 32'(ndone), 32'd0);

        // Reset mid-pass at cycle 40: two stats written, then silence.
        vec = mk(2047, 1000, 5, 42, 0, 0, 0, 999);
        run_pass(vec, 1'b1, -1, -1, 40, 1'b0, 200);
        chk("r_outs",     post_rst_outs, 32'd0);
        chk("r_nwr",      32'(nwr_a),    32'd8);
        chk("r_nwr_post", 32'(nwr_post), 32'd0);
        chk("r_ndone",    32'(ndone),    32'd0);
        chk("r_busy41",   32'(bz[41]),   32'd0);
        chk("r_s0",       32'(wa(0)),    32'h2047);
        chk("r_s1",       32'(wa(1)),    32'h1000);
        chk("r_s2",       32'(wa(2)),    32'hEEEE);

        // Normal pass after the abort.
        run_pass(vec, 1'b1, -1, -1, -1, 1'b0, 135);
        chk("a_nwr",  32'(nwr_a),    32'd32);
        chk("a_done", 32'(done_cyc), 32'd130);
        chk("a_s1",   32'(wa(1)),    32'h1000);
        chk("a_s7",   32'(wa(7)),    32'hF999);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
